// File: rtl/march_pkg.sv
// Shared types and default limits for the invader march controller slice.
package march_pkg;

  typedef enum logic [2:0] {
    MARCH_R,
    DESC_R,
    MARCH_L,
    DESC_L,
    LANDED
  } march_state_e;

  typedef logic [11:0] edge_t;

  localparam int DEF_RIGHT_LIMIT    = 600;
  localparam int DEF_LEFT_LIMIT     = 8;
  localparam int DEF_BOTTOM_LIMIT   = 400;
  localparam int DEF_FORMATION_H    = 128;
  localparam int DEF_DESCEND_FRAMES = 15;
  localparam int DEF_KILLS_PER_STEP = 5;
  localparam int DEF_MAX_LEVEL      = 7;

  // Screen coordinates are 11 bits; sums are widened so they never wrap.
  function automatic edge_t widenSum(input logic [10:0] a, input logic [10:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/invader_speed_ladder.sv
// Kill counter and speed level: every KILLS_PER_STEP kills raises the level
// by one (saturating at MAX_LEVEL) and emits a one-cycle speedUp pulse.
module invader_speed_ladder
  import march_pkg::*;
#(
  parameter int KILLS_PER_STEP = DEF_KILLS_PER_STEP,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       gameRestart,
  input  logic       invaderKilled,
  output logic       speedUp,
  output logic [2:0] speedLevel
);

  logic [5:0] killCnt_q, killCnt_d;
  logic [2:0] level_q, level_d;
  logic       speedUp_q, speedUp_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      killCnt_q <= '0;
      level_q   <= '0;
      speedUp_q <= 1'b0;
    end else begin
      killCnt_q <= killCnt_d;
      level_q   <= level_d;
      speedUp_q <= speedUp_d;
    end
  end

  // The counter wraps on every step even when the level is already saturated.
  always_comb begin
    killCnt_d = killCnt_q;
    level_d   = level_q;
    speedUp_d = 1'b0;
    if (gameRestart) begin
      killCnt_d = '0;
      level_d   = '0;
    end else if (invaderKilled) begin
      if (killCnt_q == 6'(KILLS_PER_STEP - 1)) begin
        killCnt_d = '0;
        if (level_q < 3'(MAX_LEVEL)) begin
          level_d   = level_q + 3'd1;
          speedUp_d = 1'b1;
        end
      end else begin
        killCnt_d = killCnt_q + 6'd1;
      end
    end
  end

  assign speedUp    = speedUp_q;
  assign speedLevel = level_q;

endmodule

// File: rtl/invader_march_ctrl.sv
// Formation march controller: edge turns, timed descents, speed ladder.
// Define MARCH_BOTTOM_DETECT_EN to enable landing detection (LANDED state).
module invader_march_ctrl
  import march_pkg::*;
#(
  parameter int RIGHT_LIMIT    = DEF_RIGHT_LIMIT,
  parameter int LEFT_LIMIT     = DEF_LEFT_LIMIT,
  parameter int BOTTOM_LIMIT   = DEF_BOTTOM_LIMIT,
  parameter int FORMATION_H    = DEF_FORMATION_H,
  parameter int DESCEND_FRAMES = DEF_DESCEND_FRAMES,
  parameter int KILLS_PER_STEP = DEF_KILLS_PER_STEP,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic [10:0] leftColOffset,
  input  logic [10:0] rightColOffset,
  input  logic        invaderKilled,
  input  logic        gameRestart,
  output logic        chgDir,
  output logic        descendDone,
  output logic        speedUp,
  output logic [2:0]  speedLevel,
  output logic        dirRight,
  output logic        reachedBottom
);

  march_state_e state_q, state_d;
  logic [7:0]   descCnt_q, descCnt_d;
  logic         dirRight_q, dirRight_d;
  logic         chgDir_q, chgDir_d;
  logic         descendDone_q, descendDone_d;
  logic         reachedBottom_q, reachedBottom_d;

  edge_t rightEdge, leftEdge;
  logic  edgesValid, rightHit, leftHit, bottomHit;

  assign rightEdge  = widenSum(topLeftX, rightColOffset);
  assign leftEdge   = widenSum(topLeftX, leftColOffset);
  // An all-dead formation has no meaningful extents, so it never turns.
  assign edgesValid = (leftColOffset <= rightColOffset);
  assign rightHit   = edgesValid && (rightEdge >= edge_t'(RIGHT_LIMIT));
  assign leftHit    = edgesValid && (leftEdge <= edge_t'(LEFT_LIMIT));

`ifdef MARCH_BOTTOM_DETECT_EN
  edge_t bottom;
  assign bottom    = widenSum(topLeftY, 11'(FORMATION_H));
  assign bottomHit = (bottom >= edge_t'(BOTTOM_LIMIT));
`else
  logic unusedBottom;
  assign unusedBottom = ^topLeftY;
  assign bottomHit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= MARCH_R;
      descCnt_q       <= '0;
      dirRight_q      <= 1'b1;
      chgDir_q        <= 1'b0;
      descendDone_q   <= 1'b0;
      reachedBottom_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      descCnt_q       <= descCnt_d;
      dirRight_q      <= dirRight_d;
      chgDir_q        <= chgDir_d;
      descendDone_q   <= descendDone_d;
      reachedBottom_q <= reachedBottom_d;
    end
  end

  // Landing outranks any turn or descent completion evaluated in the same frame.
  always_comb begin
    state_d         = state_q;
    descCnt_d       = descCnt_q;
    dirRight_d      = dirRight_q;
    chgDir_d        = 1'b0;
    descendDone_d   = 1'b0;
    reachedBottom_d = reachedBottom_q;
    if (gameRestart) begin
      state_d         = MARCH_R;
      descCnt_d       = '0;
      dirRight_d      = 1'b1;
      reachedBottom_d = 1'b0;
    end else if (startOfFrame) begin
      if (bottomHit && state_q != LANDED) begin
        state_d         = LANDED;
        reachedBottom_d = 1'b1;
      end else begin
        case (state_q)
          MARCH_R: begin
            if (rightHit) begin
              chgDir_d  = 1'b1;
              descCnt_d = 8'(DESCEND_FRAMES);
              state_d   = DESC_R;
            end
          end
          DESC_R: begin
            descCnt_d = descCnt_q - 8'd1;
            if (descCnt_q == 8'd1) begin
              descendDone_d = 1'b1;
              dirRight_d    = 1'b0;
              state_d       = MARCH_L;
            end
          end
          MARCH_L: begin
            if (leftHit) begin
              chgDir_d  = 1'b1;
              descCnt_d = 8'(DESCEND_FRAMES);
              state_d   = DESC_L;
            end
          end
          DESC_L: begin
            descCnt_d = descCnt_q - 8'd1;
            if (descCnt_q == 8'd1) begin
              descendDone_d = 1'b1;
              dirRight_d    = 1'b1;
              state_d       = MARCH_R;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  invader_speed_ladder #(
    .KILLS_PER_STEP(KILLS_PER_STEP),
    .MAX_LEVEL     (MAX_LEVEL)
  ) uLadder (
    .clk          (clk),
    .resetN       (resetN),
    .gameRestart  (gameRestart),
    .invaderKilled(invaderKilled),
    .speedUp      (speedUp),
    .speedLevel   (speedLevel)
  );

  assign chgDir        = chgDir_q;
  assign descendDone   = descendDone_q;
  assign dirRight      = dirRight_q;
  assign reachedBottom = reachedBottom_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Directed bench for invader_march_ctrl: turns, descents, speed ladder, resets
// and, when MARCH_BOTTOM_DETECT_EN is defined, landing.
module tb_invader_march_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] topLeftX = 11'd100;
  logic [10:0] topLeftY = 11'd0;
  logic [10:0] leftColOffset = 11'd0;
  logic [10:0] rightColOffset = 11'd100;
  logic        invaderKilled = 1'b0;
  logic        gameRestart = 1'b0;
  logic        chgDir, descendDone, speedUp, dirRight, reachedBottom;
  logic [2:0]  speedLevel;

  int assertCount = 0;
  int failCount = 0;
  int pulses;

  always #5 clk = ~clk;

  invader_march_ctrl dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .leftColOffset (leftColOffset),
    .rightColOffset(rightColOffset),
    .invaderKilled (invaderKilled),
    .gameRestart   (gameRestart),
    .chgDir        (chgDir),
    .descendDone   (descendDone),
    .speedUp       (speedUp),
    .speedLevel    (speedLevel),
    .dirRight      (dirRight),
    .reachedBottom (reachedBottom)
  );

  // Drives one clock cycle of strobes from a falling edge to the next one.
  task automatic applyStimulus(input logic sof, input logic kill, input logic restart);
    startOfFrame  = sof;
    invaderKilled = kill;
    gameRestart   = restart;
    @(negedge clk);
    startOfFrame  = 1'b0;
    invaderKilled = 1'b0;
    gameRestart   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic cd, input logic dd, input logic su,
                          input logic [2:0] lvl, input logic dr, input logic rb);
    checkOutput({tag, ".chgDir"}, {31'd0, chgDir}, {31'd0, cd});
    checkOutput({tag, ".descendDone"}, {31'd0, descendDone}, {31'd0, dd});
    checkOutput({tag, ".speedUp"}, {31'd0, speedUp}, {31'd0, su});
    checkOutput({tag, ".speedLevel"}, {29'd0, speedLevel}, {29'd0, lvl});
    checkOutput({tag, ".dirRight"}, {31'd0, dirRight}, {31'd0, dr});
    checkOutput({tag, ".reachedBottom"}, {31'd0, reachedBottom}, {31'd0, rb});
  endtask

  // Runs a full descent: frames-1 quiet frames, then the completing frame.
  task automatic runDescent(input string tag, input logic expDir);
    for (int i = 1; i < 15; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput({tag, ".noDone"}, {31'd0, descendDone}, 32'd0);
      checkOutput({tag, ".noChg"}, {31'd0, chgDir}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, ".done"}, {31'd0, descendDone}, 32'd1);
    checkOutput({tag, ".dir"}, {31'd0, dirRight}, {31'd0, expDir});
    checkOutput({tag, ".doneChg"}, {31'd0, chgDir}, 32'd0);
    @(negedge clk);
    checkOutput({tag, ".doneWidth"}, {31'd0, descendDone}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkAll("reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    resetN = 1'b1;
    @(negedge clk);

    topLeftX = 11'd40; leftColOffset = 11'd0; rightColOffset = 11'd559;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rightEdge599", {31'd0, chgDir}, 32'd0);

    rightColOffset = 11'd560;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("turnRight", {31'd0, chgDir}, 32'd1);
    @(negedge clk);
    checkOutput("turnRightWidth", {31'd0, chgDir}, 32'd0);
    runDescent("descR", 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("marchLNoRightTurn", {31'd0, chgDir}, 32'd0);

    topLeftX = 11'd4; leftColOffset = 11'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("turnLeft", {31'd0, chgDir}, 32'd1);
    runDescent("descL", 1'b1);

    topLeftX = 11'd40; leftColOffset = 11'd600; rightColOffset = 11'd560;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("zeroWidthHold", {31'd0, chgDir}, 32'd0);
    leftColOffset = 11'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("turnAfterZeroWidth", {31'd0, chgDir}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("killNoStep", {31'd0, speedUp}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fifthKillPulse", {31'd0, speedUp}, 32'd1);
    checkOutput("level1", {29'd0, speedLevel}, 32'd1);
    @(negedge clk);
    checkOutput("speedUpWidth", {31'd0, speedUp}, 32'd0);
    pulses = 1;
    for (int i = 0; i < 35; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (speedUp) pulses++;
    end
    checkOutput("pulsesAfter40", pulses, 32'd7);
    checkOutput("level7", {29'd0, speedLevel}, 32'd7);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (speedUp) pulses++;
    end
    checkOutput("saturatedNoPulse", pulses, 32'd0);
    checkOutput("level7Held", {29'd0, speedLevel}, 32'd7);

    applyStimulus(1'b0, 1'b1, 1'b1);
    checkAll("restartWithKill", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restartToMarchR", {31'd0, chgDir}, 32'd1);
    runDescent("descR2", 1'b0);
    topLeftX = 11'd4; leftColOffset = 11'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("turnLeft2", {31'd0, chgDir}, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("levelBeforeReset", {29'd0, speedLevel}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    checkAll("asyncReset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    topLeftX = 11'd40; leftColOffset = 11'd0; rightColOffset = 11'd560;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resetToMarchR", {31'd0, chgDir}, 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef MARCH_BOTTOM_DETECT_EN
    topLeftY = 11'd271;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bottom399", {31'd0, reachedBottom}, 32'd0);
    checkOutput("bottom399Turn", {31'd0, chgDir}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    topLeftY = 11'd272;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("landed", {31'd0, reachedBottom}, 32'd1);
    checkOutput("landedNoTurn", {31'd0, chgDir}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("landedQuietChg", {31'd0, chgDir}, 32'd0);
      checkOutput("landedQuietDone", {31'd0, descendDone}, 32'd0);
    end
    checkOutput("landedSticky", {31'd0, reachedBottom}, 32'd1);
    topLeftY = 11'd0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("restartFromLanded", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
`else
    topLeftY = 11'd272;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("noLandTurn", {31'd0, chgDir}, 32'd1);
    checkOutput("noLandFlag", {31'd0, reachedBottom}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
